// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep controller feeding the DDS phase-increment input.
// Steps P from start to stop (inclusive), holding each value dwell+1 enabled cycles.
module dds_sweep_ctrl #(
    parameter int M = 24,
    parameter int D = 16
) (
    input  logic         clk,
    input  logic         rst_ac,
    input  logic         ena_ac,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [M-1:0] P_start,
    input  logic [M-1:0] P_stop,
    input  logic [M-1:0] P_step,
    input  logic [D-1:0] dwell,
    output logic [M-1:0] P,
    output logic         val_out,
    output logic         busy,
    output logic         done,
    output logic         wrap
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SWEEP = 1'b1;

    logic [0:0]   r_state;
    logic [D-1:0] r_cnt;
    logic [M-1:0] r_start;
    logic [M-1:0] r_stop;
    logic [M-1:0] r_step;
    logic [D-1:0] r_dwell;
    logic         r_mode;

    // The extra carry bit makes any modulo-2^M wrap count as overshoot.
    logic [M:0]   w_next;
    logic         w_over;

    assign w_next = {1'b0, P} + {1'b0, r_step};
    assign w_over = (w_next > {1'b0, r_stop});

    // NOTE: every register here uses non-blocking assignment so all updates
    // are taken from the same pre-edge values, matching real flip-flops.
    always_ff @(posedge clk or negedge rst_ac) begin
        if (!rst_ac) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_mode  <= 1'b0;
            P       <= '0;
            val_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            // Pulses last one cycle and are cleared on disabled edges as well.
            done <= 1'b0;
            wrap <= 1'b0;
            if (ena_ac) begin
                case (r_state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            r_start <= P_start;
                            r_stop  <= P_stop;
                            r_step  <= P_step;
                            r_dwell <= dwell;
                            r_mode  <= mode;
                            P       <= P_start;
                            r_cnt   <= '0;
                            val_out <= 1'b1;
                            busy    <= 1'b1;
                            r_state <= S_SWEEP;
                        end
                    end
                    S_SWEEP: begin
                        if (stop) begin
                            val_out <= 1'b0;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (r_cnt < r_dwell) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_cnt <= '0;
                            if (!w_over) begin
                                P <= w_next[M-1:0];
                            end else if (r_mode) begin
                                P    <= r_start;
                                wrap <= 1'b1;
                            end else begin
                                val_out <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        val_out <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a sweep-plan model pushes per-cycle
// expectations that a negedge monitor pops and compares against the DUT.
module tb_dds_sweep_ctrl;

    localparam int M = 24;
    localparam int D = 16;
    localparam logic [M-1:0] P_MAX = {M{1'b1}};

    logic         clk;
    logic         rst_ac;
    logic         ena_ac;
    logic         start;
    logic         stop;
    logic         mode;
    logic [M-1:0] P_start;
    logic [M-1:0] P_stop;
    logic [M-1:0] P_step;
    logic [D-1:0] dwell;
    logic [M-1:0] P;
    logic         val_out;
    logic         busy;
    logic         done;
    logic         wrap;

    int n_checks = 0;
    int n_fail   = 0;

    dds_sweep_ctrl #(.M(M), .D(D)) dut (
        .clk     (clk),
        .rst_ac  (rst_ac),
        .ena_ac  (ena_ac),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .P_start (P_start),
        .P_stop  (P_stop),
        .P_step  (P_step),
        .dwell   (dwell),
        .P       (P),
        .val_out (val_out),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model: a sweep is a list of P values,
    // each shown hold = dwell+1 cycles; time within the sweep is an index.
    typedef struct {
        logic [M-1:0] p;
        logic         val;
        logic         bsy;
        logic         dn;
        logic         wr;
    } exp_t;

    exp_t         q[$];
    logic [M-1:0] m_vals[$];
    int           m_hold;
    int           m_idx;
    bit           m_inf;
    bit           m_mode;
    bit           m_busy;
    bit           m_done;
    bit           m_wrap;
    logic [M-1:0] m_p;

    function automatic void model_clear();
        m_busy = 0;
        m_done = 0;
        m_wrap = 0;
        m_p    = '0;
        m_idx  = 0;
        m_vals.delete();
    endfunction

    function automatic void model_start();
        longint v;
        m_vals.delete();
        m_vals.push_back(P_start);
        if (P_step != 0) begin
            v = longint'(P_start) + longint'(P_step);
            while (v <= longint'(P_stop)) begin
                m_vals.push_back(v[M-1:0]);
                v += longint'(P_step);
            end
        end
        m_inf  = (P_step == 0) && (P_start <= P_stop);
        m_hold = int'(dwell) + 1;
        m_mode = mode;
        m_idx  = 0;
        m_busy = 1;
    endfunction

    always @(negedge rst_ac) begin
        model_clear();
        q.delete();
    end

    always @(posedge clk) begin
        m_done = 0;
        m_wrap = 0;
        if (!rst_ac) begin
            model_clear();
        end else if (ena_ac) begin
            if (!m_busy) begin
                if (start && !stop) model_start();
            end else if (stop) begin
                m_busy = 0;
            end else begin
                m_idx++;
                if (!m_inf && m_idx == m_vals.size() * m_hold) begin
                    if (m_mode) begin
                        m_idx  = 0;
                        m_wrap = 1;
                    end else begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
            if (m_busy) m_p = m_vals[m_inf ? 0 : m_idx / m_hold];
        end
        q.push_back('{m_p, m_busy, m_busy, m_done, m_wrap});
    end

    // ---------------- monitor
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("P",       64'(P),       64'(e.p));
            check("val_out", 64'(val_out), 64'(e.val));
            check("busy",    64'(busy),    64'(e.bsy));
            check("done",    64'(done),    64'(e.dn));
            check("wrap",    64'(wrap),    64'(e.wr));
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic begin_sweep(input logic [M-1:0] ps, input logic [M-1:0] pe,
                               input logic [M-1:0] st, input logic [D-1:0] dw,
                               input logic md);
        P_start = ps;
        P_stop  = pe;
        P_step  = st;
        dwell   = dw;
        mode    = md;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_ac  = 1'b0;
        ena_ac  = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 1'b0;
        P_start = '0;
        P_stop  = '0;
        P_step  = '0;
        dwell   = '0;
        run(3);
        check("reset_P",   64'(P),       64'd0);
        check("reset_val", 64'(val_out), 64'd0);
        rst_ac = 1'b1;
        run(2);

        // Single sweep 100..130 step 10, dwell 2, with bounded wait on done.
        begin_sweep(24'd100, 24'd130, 24'd10, 16'd2, 1'b0);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("single_done_seen", 64'(seen), 64'd1);
        check("single_P_hold", 64'(P), 64'd130);
        run(3);

        // Repeating sawtooth 0,7,14 then abort.
        begin_sweep(24'd0, 24'd20, 24'd7, 16'd0, 1'b1);
        run(10);
        abort();
        run(3);

        // Top-of-range overshoot must not wrap modulo 2^M.
        begin_sweep(24'd16777211, 24'd16777215, 24'd4, 16'd0, 1'b0);
        run(5);

        // start during SWEEP is ignored, even with a different config.
        begin_sweep(24'd50, 24'd80, 24'd15, 16'd1, 1'b0);
        P_start = 24'd999;
        start   = 1'b1;
        run(3);
        start   = 1'b0;
        run(6);
        // start+stop together in IDLE stays IDLE.
        start = 1'b1;
        stop  = 1'b1;
        run(3);
        start = 1'b0;
        stop  = 1'b0;
        check("idle_start_stop_val", 64'(val_out), 64'd0);
        run(2);

        // Enable freeze mid-dwell.
        begin_sweep(24'd10, 24'd40, 24'd10, 16'd3, 1'b0);
        run(2);
        ena_ac = 1'b0;
        run(5);
        ena_ac = 1'b1;
        run(20);

        // Asynchronous reset mid-sweep, then a normal sweep.
        begin_sweep(24'd200, 24'd300, 24'd20, 16'd1, 1'b1);
        run(4);
        #2 rst_ac = 1'b0;
        #1;
        check("async_rst_P",    64'(P),       64'd0);
        check("async_rst_val",  64'(val_out), 64'd0);
        check("async_rst_busy", 64'(busy),    64'd0);
        check("async_rst_done", 64'(done),    64'd0);
        run(2);
        rst_ac = 1'b1;
        run(1);
        begin_sweep(24'd5, 24'd25, 24'd5, 16'd0, 1'b0);
        run(8);

        // Randomized sweeps with random enable, stop and start traffic.
        for (int it = 0; it < 30; it++) begin
            logic [M-1:0] ps;
            if ($urandom_range(0, 9) == 0) ps = P_MAX - M'($urandom_range(1, 40));
            else ps = M'($urandom_range(0, 200));
            begin_sweep(ps,
                        ($urandom_range(0, 9) == 0) ? P_MAX : ps + M'($urandom_range(0, 60)) - M'(5),
                        M'($urandom_range(0, 25)),
                        D'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)));
            for (int c = 0; c < int'($urandom_range(5, 45)); c++) begin
                ena_ac  = ($urandom_range(0, 99) < 85);
                stop    = ($urandom_range(0, 99) < 4);
                start   = ($urandom_range(0, 99) < 10);
                P_start = M'($urandom_range(0, 100));
                P_stop  = M'($urandom_range(50, 150));
                P_step  = M'($urandom_range(1, 20));
                dwell   = D'($urandom_range(0, 2));
                mode    = 1'($urandom_range(0, 1));
                tick();
            end
            ena_ac = 1'b1;
            start  = 1'b0;
            abort();
            run(2);
        end

        run(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Linear frequency-sweep controller that sits directly upstream of the DDS stage. It generates the M-bit phase increment `P` and its `val_in` qualifier, stepping `P` from a start value to a stop value at a programmable rate. Each sweep is either single-shot or repeating (sawtooth), so the DDS emits chirps without host involvement per step.

## Interface
Parameters:
- `M`, 24, phase-increment width; matches DDS `M`.
- `D`, 16, dwell-counter width.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst_ac`  in  1  reset, asynchronous, active-low.
- `ena_ac`  in  1  clock enable; low freezes all state.
- `start`  in  1  sweep start request, sampled when `ena_ac`=1.
- `stop`  in  1  sweep abort request, sampled when `ena_ac`=1.
- `mode`  in  1  0 = single sweep, 1 = repeating sweep.
- `P_start`  in  M  first phase increment.
- `P_stop`  in  M  upper bound, inclusive.
- `P_step`  in  M  increment added per step.
- `dwell`  in  D  extra cycles each `P` value is held (hold = `dwell`+1 cycles).
- `P`  out  M  phase increment to the DDS `P` input.
- `val_out`  out  1  drives DDS `val_in`; high while sweeping.
- `busy`  out  1  high in state SWEEP.
- `done`  out  1  one-cycle pulse on normal single-sweep completion.
- `wrap`  out  1  one-cycle pulse when a repeating sweep restarts.

## Operation
- States: IDLE, SWEEP.
- Reset (`rst_ac`=0, async): state IDLE; `P`=0, `val_out`=0, `busy`=0, `done`=0, `wrap`=0; dwell counter and config registers cleared.
- `ena_ac`=0: no state, counter, `P` or config change. `done` and `wrap` are forced 0. `val_out` and `busy` hold.
- IDLE, `start`=1, `stop`=0:
  - Latch `P_start`, `P_stop`, `P_step`, `dwell` and `mode` into internal registers.
  - Set `P`←`P_start`, dwell count←0, `val_out`←1, `busy`←1, state←SWEEP.
  - Input config is ignored after the latch, until the next start.
- IDLE, `start`=1 and `stop`=1: stay IDLE, no change.
- SWEEP, `stop`=1: highest priority.
  - Next edge: state←IDLE, `val_out`←0, `busy`←0.
  - `done` is not pulsed; `P` holds its current value.
- SWEEP, `start`: ignored.
- SWEEP step rule (on each enabled edge, no `stop`):
  - If count < dwell_r: count←count+1.
  - Otherwise count←0 and compute next = `P` + step_r at M+1 bits.
  - next ≤ stop_r (carry bit clear): `P`←next.
  - next > stop_r or carry set, `mode`_r=0: state←IDLE, `val_out`←0, `busy`←0, `done`←1 for one cycle, `P` holds last value.
  - next > stop_r or carry set, `mode`_r=1: `P`←start_r, `wrap`←1 for one cycle, remain in SWEEP.
- `P` never wraps modulo 2^M; the carry always counts as overshoot.
- `P_start` > `P_stop`: `P_start` is output for `dwell`+1 cycles, then the sweep ends (single) or repeats (`mode`=1).
- `P_step`=0: `P` is held at `P_start` until `stop`.
- In IDLE, `P` holds its last value; `val_out`=0.

## Timing
- All outputs are registered.
- `start` sampled at edge k: `P`=`P_start` and `val_out`=1 from just after edge k.
- Each `P` value is valid for exactly `dwell`+1 enabled cycles.
- Single sweep of N values: `val_out` high for N·(`dwell`+1) enabled cycles. `done` rises on the same edge `val_out` falls and lasts one cycle.
- `wrap` is high during the first cycle of `P`=start_r after a restart.
- `stop` at edge k: `val_out`=0 after edge k.
- A new `start` is accepted on the first enabled edge with state IDLE, including the edge immediately after `done` rises.

## Test plan
- Reset mid-sweep: drop `rst_ac` asynchronously during SWEEP -> `P`=0, `val_out`=0, `busy`=0, `done`=0 before the next clock edge; release, then `start` -> normal sweep.
- Single sweep, `P_start`=100, `P_stop`=130, `P_step`=10, `dwell`=2 -> `P` = 100,110,120,130, each for 3 cycles; `val_out` high 12 cycles; then one-cycle `done`; `P` holds 130.
- Repeating sweep, start=0, stop=20, step=7, dwell=0, `mode`=1 -> `P` = 0,7,14,0,7,14,…; `wrap`=1 on each return to 0; `stop` -> IDLE next cycle, `done` stays 0.
- Overflow, start=16777211, stop=16777215, step=4, dwell=0 -> `P` = 16777211, 16777215, then `done`; `P` never shows 3.
- Priority: `start` during SWEEP ignored (sequence unchanged); `start`+`stop` together in IDLE -> stays IDLE, `val_out`=0.
- Enable: `ena_ac`=0 for 5 cycles in the middle of a dwell with `dwell`=3 -> `P`, count and `val_out` frozen; after re-enable, the remaining dwell cycles complete and the sequence matches the uninterrupted run shifted by 5 cycles.
